mips_mc_sequencer: RTL

- Multi-cycle control sequencer for the MIPS core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives instruction/data memory request handshakes and register-file/PC write enables from the decoder's control outputs.
- Handles syscall halt, reserved-instruction and bus-timeout exceptions, and holds the core halted afterwards.

---
 rtl/mips_mc_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_sequencer.sv
// mips_mc_sequencer: multi-cycle control sequencer for the MIPS core.
// Each instruction moves through FETCH, DECODE, EXEC, optional MEM, and
// optional WB. Exceptions pass through EXC (EPC capture) into HALT. HALT is
// sticky until reset.
//
// Parameters:
//   MEM_TIMEOUT : max wait cycles on imem/dmem ack before a bus timeout (1..65535)
//   CNT_W       : width of the retired-instruction counter
//
// Ports:
//   clk, rst_b             : clock (rising edge), async active-low reset
//   ctrl_we, ctrl_Sys, ctrl_RI, mem_to_reg, mem_op, sys_halt : decoder controls
//   imem_req/imem_ack      : instruction fetch handshake
//   dmem_req/dmem_ack      : data memory handshake
//   ir_en, rf_we, pc_en, epc_en : datapath strobes
//   halted, exc_code       : sticky halt flag, exception cause (01 RI, 10 timeout)
//   instr_count            : retired-instruction count (wraps)
//   state                  : current FSM state (debug)
//   step                   : single-step release (only with MIPS_SEQ_SINGLE_STEP_EN)
//
// Optional build macro MIPS_SEQ_SINGLE_STEP_EN: after each retirement the
// FSM parks in PAUSE until step=1 instead of going straight to FETCH.
module mips_mc_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             ctrl_we,
  input  logic             ctrl_Sys,
  input  logic             ctrl_RI,
  input  logic             mem_to_reg,
  input  logic             mem_op,
  input  logic             sys_halt,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic             ir_en,
  output logic             rf_we,
  output logic             pc_en,
  output logic             epc_en,
  output logic             halted,
  output logic [1:0]       exc_code,
`ifdef MIPS_SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_WB     = 4'd4,
    S_EXC    = 4'd5,
    S_HALT   = 4'd6,
    S_PAUSE  = 4'd7
  } state_t;

`ifdef MIPS_SEQ_SINGLE_STEP_EN
  localparam state_t S_AFTER_RETIRE = S_PAUSE;
`else
  localparam state_t S_AFTER_RETIRE = S_FETCH;
`endif

  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

  state_t      cur, nxt;
  logic [1:0]  exc_nxt;
  logic [15:0] wait_cnt;
  logic        wait_inc;
  logic        retire;

  // Strobes are decoded from the current state and this cycle's inputs, so
  // ir_en and pc_en appear in the same cycle as the ack that causes them.
  // imem_req/ir_en are gated by rst_b so the request drops the moment reset
  // asserts, even though the state register already sits in FETCH.
  always_comb begin
    nxt      = cur;
    exc_nxt  = exc_code;
    retire   = 1'b0;
    wait_inc = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ir_en    = 1'b0;
    rf_we    = 1'b0;
    epc_en   = 1'b0;
    halted   = 1'b0;
    case (cur)
      S_FETCH: begin
        imem_req = rst_b;
        if (imem_ack) begin
          ir_en = rst_b;
          nxt   = S_DECODE;
        end else if (wait_cnt == TMO) begin
          exc_nxt = 2'b10;
          nxt     = S_EXC;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (ctrl_RI) begin
          exc_nxt = 2'b01;
          nxt     = S_EXC;
        end else if (ctrl_Sys) begin
          retire = 1'b1;
          nxt    = sys_halt ? S_HALT : S_AFTER_RETIRE;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (mem_op) begin
          nxt = S_MEM;
        end else if (ctrl_we) begin
          nxt = S_WB;
        end else begin
          retire = 1'b1;
          nxt    = S_AFTER_RETIRE;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          if (mem_to_reg) begin
            nxt = S_WB;
          end else begin
            retire = 1'b1;
            nxt    = S_AFTER_RETIRE;
          end
        end else if (wait_cnt == TMO) begin
          exc_nxt = 2'b10;
          nxt     = S_EXC;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
        nxt    = S_AFTER_RETIRE;
      end
      S_EXC: begin
        epc_en = 1'b1;
        nxt    = S_HALT;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_PAUSE: begin
`ifdef MIPS_SEQ_SINGLE_STEP_EN
        if (step) nxt = S_FETCH;
`else
        nxt = S_FETCH;
`endif
      end
      default: nxt = S_FETCH;
    endcase
  end

  assign pc_en = retire;
  assign state = cur;

  // The wait counter clears whenever it is not counting, so every entry into
  // FETCH or MEM starts from zero. It stops at TMO because the timeout
  // branch takes over there.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cur         <= S_FETCH;
      exc_code    <= '0;
      instr_count <= '0;
      wait_cnt    <= '0;
    end else begin
      cur      <= nxt;
      exc_code <= exc_nxt;
      if (retire) instr_count <= instr_count + CNT_W'(1);
      if (!wait_inc)            wait_cnt <= '0;
      else if (wait_cnt != '1)  wait_cnt <= wait_cnt + 16'd1;
    end
  end

endmodule
